optimal_strip_selector: RTL and testbench
=========================================

# optimal_strip_selector

Streaming, parametrised successor to the three-input strip chooser. It scans a frame of up to MAX_CAND candidate strips, presented one per beat over a valid/ready handshake, and tracks the best (narrowest or widest) eligible strip, with earliest-arrival priority on ties. At frame end it presents the winning id and width, the eligible count and status flags on a held output handshake. It sits between the strip generator and the placement stage.

## Interface
- ID_W, 4: candidate id width.
- WIDTH_W, 7: strip width field width.
- MAX_CAND, 16: maximum candidates per frame, ≥2; CNT_W = clog2(MAX_CAND+1).
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  candidate beat valid.
- in_ready  out  1  block can accept a beat; equals !out_valid.
- in_id  in  ID_W  candidate id.
- in_width  in  WIDTH_W  candidate strip width, unsigned.
- in_elig  in  1  candidate eligible; ineligible beats are consumed but never win and are not counted.
- in_last  in  1  final beat of frame.
- mode  in  1  0 = select minimum width, 1 = select maximum; sampled on the first beat of a frame.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts the result.
- out_id  out  ID_W  winning id.
- out_width  out  WIDTH_W  winning width.
- out_count  out  CNT_W  number of eligible beats in the frame, saturating at MAX_CAND.
- out_none  out  1  no eligible beat in the frame.
- out_ovf  out  1  frame had more than MAX_CAND beats, counting eligible and ineligible.

## Operation
- States:
  - IDLE: no frame open.
  - SCAN: frame open.
  - HOLD: result presented.
- Beat accepted when in_valid && in_ready.
- IDLE, accepted beat:
  - Latch mode into frame_mode.
  - Initialise best from the beat if in_elig. Otherwise best is marked empty.
  - Set beat count = 1.
  - Go to SCAN, or directly to HOLD if in_last.
- SCAN, accepted beat:
  - An eligible beat replaces best if best is empty.
  - It also replaces best if in_width < best_width when frame_mode = 0, or in_width > best_width when frame_mode = 1.
  - Comparisons are strict. On equal widths the earlier beat is kept.
  - in_last moves the block to HOLD.
- mode changes after the first beat of a frame are ignored until the next frame.
- Eligible count increments per eligible beat and saturates at MAX_CAND.
- Total beat counter saturates at MAX_CAND+1. out_ovf = 1 if it exceeds MAX_CAND. The frame continues to be scanned normally.
- Entering HOLD:
  - Outputs are loaded from best.
  - out_none = 1 if best is empty. In that case out_id = 0 and out_width = 0.
- HOLD: all outputs stable while out_valid && !out_ready. An out_valid && out_ready handshake returns the block to IDLE and clears out_valid.
- Reset values:
  - out_valid = 0, out_id = 0, out_width = 0, out_count = 0, out_none = 0, out_ovf = 0.
  - State = IDLE, best = empty.
  - in_ready = 1.
- Beats presented while rst is high are discarded.

## Timing
- Throughput in IDLE/SCAN: one beat per cycle.
- Latency: the last beat is accepted in cycle N; out_valid = 1 in cycle N+1.
- in_ready is combinational from out_valid only. It is 0 for every cycle out_valid = 1.
- Consumer accepts in cycle M: out_valid = 0 and in_ready = 1 in cycle M+1. There is one bubble; no same-cycle bypass of a new frame.
- Single-beat frame (first beat has in_last): result is valid the next cycle.
- rst mid-frame or in HOLD: next cycle all state is at reset values. A partially scanned frame and any unaccepted result are dropped with no output.
- out_ready with out_valid = 0 has no effect.
- in_valid with in_ready = 0 has no effect, and the beat is not consumed.

## Test plan
- Min mode, priority tie. Beats (id 3, w 40), (id 5, w 20), (id 9, w 20, last), all eligible → out_id = 5, out_width = 20, out_count = 3, out_none = 0, out_ovf = 0, out_valid one cycle after the last beat.
- Max mode with a mid-frame mode flip. mode = 1 on the first beat, 0 afterwards. Beats widths 10, 90, 90, 50 with ids 1, 2, 3, 4 → out_id = 2, out_width = 90.
- Backpressure. Hold out_ready = 0 for 5 cycles after out_valid → outputs stable, in_ready = 0, and in_valid beats are not consumed. Raise out_ready → out_valid = 0 and in_ready = 1 the next cycle, then the next frame is accepted correctly.
- No eligible beats. Three beats with in_elig = 0 → out_none = 1, out_id = 0, out_width = 0, out_count = 0.
- Overflow. MAX_CAND+2 eligible beats with the minimum at the final beat (w 1) → out_width = 1, out_count = MAX_CAND, out_ovf = 1.
- Reset mid-frame. Assert rst after 2 of 4 beats → no out_valid. A following frame of one beat (id 7, w 33, last) yields out_id = 7, out_width = 33, out_count = 1.

Source files
------------

// File: rtl/optimal_strip_selector_if.sv
// Candidate-in / result-out handshake bundle for optimal_strip_selector.
// master drives candidates and accepts results; slave is the selector.
interface optimal_strip_selector_if #(
  parameter int ID_W     = 4,
  parameter int WIDTH_W  = 7,
  parameter int MAX_CAND = 16
);
  localparam int CNT_W = $clog2(MAX_CAND + 1);

  logic               in_valid;
  logic               in_ready;
  logic [ID_W-1:0]    in_id;
  logic [WIDTH_W-1:0] in_width;
  logic               in_elig;
  logic               in_last;
  logic               mode;
  logic               out_valid;
  logic               out_ready;
  logic [ID_W-1:0]    out_id;
  logic [WIDTH_W-1:0] out_width;
  logic [CNT_W-1:0]   out_count;
  logic               out_none;
  logic               out_ovf;

  modport master (
    output in_valid, in_id, in_width, in_elig, in_last, mode, out_ready,
    input  in_ready, out_valid, out_id, out_width, out_count,
    input  out_none, out_ovf
  );

  modport slave (
    input  in_valid, in_id, in_width, in_elig, in_last, mode, out_ready,
    output in_ready, out_valid, out_id, out_width, out_count,
    output out_none, out_ovf
  );
endinterface

// File: rtl/optimal_strip_selector.sv
// Streaming min/max strip selector: scans one frame of candidate beats
// and holds the earliest-arriving best eligible strip until accepted.
module optimal_strip_selector #(
  parameter int ID_W     = 4,
  parameter int WIDTH_W  = 7,
  parameter int MAX_CAND = 16
) (
  input logic clk,
  input logic rst,
  optimal_strip_selector_if.slave bus
);
  localparam int CNT_W  = $clog2(MAX_CAND + 1);
  localparam int BEAT_W = $clog2(MAX_CAND + 2);

  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

  state_t             state;
  logic               frame_mode;
  logic               best_vld;
  logic [ID_W-1:0]    best_id;
  logic [WIDTH_W-1:0] best_width;
  logic [CNT_W-1:0]   elig_cnt;
  logic [BEAT_W-1:0]  beat_cnt;

  logic               ovld;
  logic [ID_W-1:0]    oid;
  logic [WIDTH_W-1:0] owidth;
  logic [CNT_W-1:0]   ocnt;
  logic               onone;
  logic               oovf;

  logic               acc;
  logic               first;
  logic               cmp_mode;
  logic               better;
  logic               take;
  logic               nb_vld;
  logic [ID_W-1:0]    nb_id;
  logic [WIDTH_W-1:0] nb_width;
  logic [CNT_W-1:0]   ne_cnt;
  logic [BEAT_W-1:0]  nbeat;

  assign bus.in_ready  = !ovld;
  assign bus.out_valid = ovld;
  assign bus.out_id    = oid;
  assign bus.out_width = owidth;
  assign bus.out_count = ocnt;
  assign bus.out_none  = onone;
  assign bus.out_ovf   = oovf;

  assign acc      = bus.in_valid && !ovld;
  assign first    = (state == IDLE);
  assign cmp_mode = first ? bus.mode : frame_mode;

  // Strict compares keep the earlier beat on equal widths
  assign better = cmp_mode ? (bus.in_width > best_width)
                           : (bus.in_width < best_width);
  assign take   = bus.in_elig && (first || !best_vld || better);

  assign nb_vld   = take || (!first && best_vld);
  assign nb_id    = take ? bus.in_id : best_id;
  assign nb_width = take ? bus.in_width : best_width;

  always_comb begin
    ne_cnt = elig_cnt;
    nbeat  = beat_cnt;
    if (first) begin
      ne_cnt = CNT_W'(bus.in_elig);
      nbeat  = BEAT_W'(1);
    end else begin
      if (bus.in_elig && elig_cnt != CNT_W'(MAX_CAND))
        ne_cnt = elig_cnt + CNT_W'(1);
      if (beat_cnt != BEAT_W'(MAX_CAND + 1))
        nbeat = beat_cnt + BEAT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      frame_mode <= 1'b0;
      best_vld   <= 1'b0;
      best_id    <= '0;
      best_width <= '0;
      elig_cnt   <= '0;
      beat_cnt   <= '0;
      ovld       <= 1'b0;
      oid        <= '0;
      owidth     <= '0;
      ocnt       <= '0;
      onone      <= 1'b0;
      oovf       <= 1'b0;
    end else begin
      unique case (state)
        IDLE, SCAN: begin
          if (acc) begin
            frame_mode <= cmp_mode;
            best_vld   <= nb_vld;
            best_id    <= nb_id;
            best_width <= nb_width;
            elig_cnt   <= ne_cnt;
            beat_cnt   <= nbeat;
            if (bus.in_last) begin
              state  <= HOLD;
              ovld   <= 1'b1;
              oid    <= nb_vld ? nb_id : '0;
              owidth <= nb_vld ? nb_width : '0;
              ocnt   <= ne_cnt;
              onone  <= !nb_vld;
              oovf   <= (nbeat > BEAT_W'(MAX_CAND));
            end else begin
              state <= SCAN;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state    <= IDLE;
            ovld     <= 1'b0;
            best_vld <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_optimal_strip_selector.sv
// Directed bench for optimal_strip_selector: frame table plus
// backpressure and mid-frame reset sequences.
module tb_optimal_strip_selector;
  localparam int ID_W     = 4;
  localparam int WIDTH_W  = 7;
  localparam int MAX_CAND = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  optimal_strip_selector_if #(
    .ID_W(ID_W), .WIDTH_W(WIDTH_W), .MAX_CAND(MAX_CAND)
  ) bus ();

  optimal_strip_selector #(
    .ID_W(ID_W), .WIDTH_W(WIDTH_W), .MAX_CAND(MAX_CAND)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int id;
    int width;
    bit elig;
  } beat_t;

  typedef struct {
    int start;
    int n;
    bit mode_first;
    bit mode_rest;
    int exp_id;
    int exp_width;
    int exp_count;
    bit exp_none;
    bit exp_ovf;
  } frame_t;

  beat_t  beats[$];
  frame_t frames[$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.in_id     = '0;
    bus.in_width  = '0;
    bus.in_elig   = 1'b0;
    bus.in_last   = 1'b0;
    bus.mode      = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic add_beat(input int id, input int w, input bit e);
    beat_t b;
    b.id = id;
    b.width = w;
    b.elig = e;
    beats.push_back(b);
  endtask

  task automatic add_frame(input int n, input bit mf, input bit mr,
                           input int eid, input int ew, input int ec,
                           input bit en, input bit eo);
    frame_t f;
    f.start = beats.size() - n;
    f.n = n;
    f.mode_first = mf;
    f.mode_rest = mr;
    f.exp_id = eid;
    f.exp_width = ew;
    f.exp_count = ec;
    f.exp_none = en;
    f.exp_ovf = eo;
    frames.push_back(f);
  endtask

  // Drive a frame at one beat per cycle; leaves the result pending
  task automatic send(input frame_t f, input bit do_last, input string tag);
    for (int i = 0; i < f.n; i++) begin
      @(negedge clk);
      chk({tag, " in_ready during scan"}, int'(bus.in_ready), 1);
      bus.in_valid = 1'b1;
      bus.in_id    = ID_W'(beats[f.start + i].id);
      bus.in_width = WIDTH_W'(beats[f.start + i].width);
      bus.in_elig  = beats[f.start + i].elig;
      bus.in_last  = do_last && (i == f.n - 1);
      bus.mode     = (i == 0) ? f.mode_first : f.mode_rest;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic check_result(input frame_t f, input string tag);
    chk({tag, " out_valid"}, int'(bus.out_valid), 1);
    chk({tag, " in_ready"}, int'(bus.in_ready), 0);
    chk({tag, " out_id"}, int'(bus.out_id), f.exp_id);
    chk({tag, " out_width"}, int'(bus.out_width), f.exp_width);
    chk({tag, " out_count"}, int'(bus.out_count), f.exp_count);
    chk({tag, " out_none"}, int'(bus.out_none), int'(f.exp_none));
    chk({tag, " out_ovf"}, int'(bus.out_ovf), int'(f.exp_ovf));
  endtask

  task automatic accept(input string tag);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, " out_valid after accept"}, int'(bus.out_valid), 0);
    chk({tag, " in_ready after accept"}, int'(bus.in_ready), 1);
  endtask

  frame_t f;
  int     base;

  initial begin
    idle_inputs();

    add_beat(3, 40, 1); add_beat(5, 20, 1); add_beat(9, 20, 1);
    add_frame(3, 0, 0, 5, 20, 3, 0, 0);
    add_beat(1, 10, 1); add_beat(2, 90, 1);
    add_beat(3, 90, 1); add_beat(4, 50, 1);
    add_frame(4, 1, 0, 2, 90, 4, 0, 0);
    add_beat(1, 5, 0); add_beat(2, 6, 0); add_beat(3, 7, 0);
    add_frame(3, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < MAX_CAND + 1; i++) add_beat(i % 16, 60 + i, 1);
    add_beat(1, 1, 1);
    add_frame(MAX_CAND + 2, 0, 0, 1, 1, MAX_CAND, 0, 1);
    add_beat(1, 120, 0); add_beat(2, 30, 1);
    add_beat(3, 80, 1); add_beat(4, 127, 0);
    add_frame(4, 1, 1, 3, 80, 2, 0, 0);
    add_beat(7, 33, 1);
    add_frame(1, 1, 0, 7, 33, 1, 0, 0);

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset out_valid", int'(bus.out_valid), 0);
    chk("reset in_ready", int'(bus.in_ready), 1);
    chk("reset out_id", int'(bus.out_id), 0);
    chk("reset out_width", int'(bus.out_width), 0);
    chk("reset out_count", int'(bus.out_count), 0);
    chk("reset out_none", int'(bus.out_none), 0);
    chk("reset out_ovf", int'(bus.out_ovf), 0);

    foreach (frames[k]) begin
      send(frames[k], 1'b1, $sformatf("frame%0d", k));
      check_result(frames[k], $sformatf("frame%0d", k));
      accept($sformatf("frame%0d", k));
    end

    // Backpressure: a pending beat must not be consumed while held
    base = beats.size();
    add_beat(6, 12, 1);
    add_frame(1, 0, 0, 6, 12, 1, 0, 0);
    f = frames[frames.size() - 1];
    send(f, 1'b1, "bp");
    bus.in_valid = 1'b1;
    bus.in_id    = 4'd8;
    bus.in_width = 7'd99;
    bus.in_elig  = 1'b1;
    bus.in_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check_result(f, $sformatf("bp hold%0d", c));
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    accept("bp");
    add_beat(10, 44, 1); add_beat(11, 43, 1);
    add_frame(2, 0, 0, 11, 43, 2, 0, 0);
    f = frames[frames.size() - 1];
    send(f, 1'b1, "bp next");
    check_result(f, "bp next");
    accept("bp next");

    // Reset mid-frame, with a beat presented during reset
    add_beat(1, 10, 1); add_beat(2, 11, 1);
    add_frame(2, 0, 0, 0, 0, 0, 0, 0);
    f = frames[frames.size() - 1];
    send(f, 1'b0, "rstmid");
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_id    = 4'd12;
    bus.in_width = 7'd2;
    bus.in_elig  = 1'b1;
    bus.in_last  = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("rstmid out_valid", int'(bus.out_valid), 0);
      chk("rstmid in_ready", int'(bus.in_ready), 1);
      @(negedge clk);
    end
    f = frames[5];
    send(f, 1'b1, "rstmid next");
    check_result(f, "rstmid next");
    accept("rstmid next");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
